// File: rtl/byte_counter_pkg.sv
// Shared types and helpers for the byte_counter free-running counter.
// Honours BYTE_COUNTER_SATURATE_EN (saturate at all-ones instead of wrapping).
package byte_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // Reference next-value for widths up to 32 bits; sum kept one bit wider to catch overflow.
    function automatic logic [31:0] next_count(input logic [31:0] cur,
                                               input int unsigned step,
                                               input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        max = (33'd1 << width) - 33'd1;
        sum = {1'b0, cur} + {1'b0, step};
`ifdef BYTE_COUNTER_SATURATE_EN
        if (sum > max) begin
            return max[31:0];
        end
        return sum[31:0];
`else
        return sum[31:0] & max[31:0];
`endif
    endfunction

endpackage

// File: rtl/byte_counter_if.sv
// Output bundle of byte_counter: the registered count value.
// The counter drives it through the master modport; consumers use slave.
interface byte_counter_if
    import byte_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] count_value;

    modport master (output count_value);
    modport slave  (input  count_value);

endinterface

// File: rtl/byte_counter_next.sv
// Combinational next-value logic: add STEP, detect overflow, then wrap or saturate.
// Saturation selected by BYTE_COUNTER_SATURATE_EN; default build wraps modulo 2**WIDTH.
module byte_counter_next
    import byte_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH:0] sum;
    logic           overflow;

    assign sum      = {1'b0, cur_i} + (WIDTH + 1)'(STEP);
    assign overflow = sum[WIDTH];

`ifdef BYTE_COUNTER_SATURATE_EN
    always_comb begin
        next_o = sum[WIDTH-1:0];
        if (overflow) begin
            next_o = '1;
        end
    end
`else
    // Wrap build drops the carry on purpose.
    logic unused_overflow;
    assign unused_overflow = overflow;

    always_comb begin
        next_o = sum[WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/byte_counter.sv
// Free-running up-counter with registered output and synchronous active-low reset.
// BYTE_COUNTER_SATURATE_EN makes the counter hold at all-ones instead of wrapping.
module byte_counter
    import byte_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned STEP        = 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic           clk,
    input  logic           reset,
    byte_counter_if.master cnt_if
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_next;

    byte_counter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .cur_i  (count_q),
        .next_o (count_next)
    );

    always_comb begin
        count_d = count_next;
    end

    // Reset wins over counting; no initial value, so X until the first reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= WIDTH'(RESET_VALUE);
        end else begin
            count_q <= count_d;
        end
    end

    assign cnt_if.count_value = count_q;

endmodule

// File: tb/tb_byte_counter.sv
// Directed self-checking bench for byte_counter: default 8-bit instance plus a WIDTH=4, STEP=3 one.
// Expected values follow BYTE_COUNTER_SATURATE_EN when it is defined.
module tb_byte_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    byte_counter_if #(.WIDTH(8)) if8 ();
    byte_counter_if #(.WIDTH(4)) if4 ();

    byte_counter #(
        .WIDTH       (8),
        .STEP        (1),
        .RESET_VALUE (0)
    ) dut8 (
        .clk    (clk),
        .reset  (reset),
        .cnt_if (if8)
    );

    byte_counter #(
        .WIDTH       (4),
        .STEP        (3),
        .RESET_VALUE (0)
    ) dut4 (
        .clk    (clk),
        .reset  (reset),
        .cnt_if (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if8.count_value !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold8 edge %0d: got %0h want 0", i, if8.count_value);
            end
            n_checks++;
            if (if4.count_value !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_hold4 edge %0d: got %0h want 0", i, if4.count_value);
            end
        end
    endtask

    task automatic test_count();
        reset = 1'b1;
        for (int i = 1; i <= 129; i++) begin
            tick();
            n_checks++;
            if (if8.count_value !== 8'(i)) begin
                n_fail++;
                $display("FAIL count edge %0d: got %0d want %0d", i, if8.count_value, i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        apply_reset();
        for (int i = 1; i <= 300; i++) begin
            tick();
`ifdef BYTE_COUNTER_SATURATE_EN
            exp = (i >= 255) ? 8'd255 : 8'(i);
`else
            exp = 8'(i % 256);
`endif
            n_checks++;
            if (if8.count_value !== exp) begin
                n_fail++;
                $display("FAIL wrap edge %0d: got %0d want %0d", i, if8.count_value, exp);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (if8.count_value !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_then_reset: got %0d want 0", if8.count_value);
        end
        reset = 1'b1;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (100) tick();
        n_checks++;
        if (if8.count_value !== 8'd100) begin
            n_fail++;
            $display("FAIL mid_reach100: got %0d want 100", if8.count_value);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (if8.count_value !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %0d want 0", if8.count_value);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (if8.count_value !== 8'd1) begin
            n_fail++;
            $display("FAIL mid_resume1: got %0d want 1", if8.count_value);
        end
        tick();
        n_checks++;
        if (if8.count_value !== 8'd2) begin
            n_fail++;
            $display("FAIL mid_resume2: got %0d want 2", if8.count_value);
        end
    endtask

    task automatic test_param_w4_s3();
        logic [3:0] exp4 [7];
`ifdef BYTE_COUNTER_SATURATE_EN
        exp4 = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15, 4'd15};
`else
        exp4 = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5};
`endif
        reset = 1'b0;
        tick();
        n_checks++;
        if (if4.count_value !== 4'd0) begin
            n_fail++;
            $display("FAIL w4_reset: got %0d want 0", if4.count_value);
        end
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (if4.count_value !== exp4[i]) begin
                n_fail++;
                $display("FAIL w4_step edge %0d: got %0d want %0d", i + 1, if4.count_value,
                         exp4[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_wrap();
        test_mid_reset();
        test_param_w4_s3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
